// File: rtl/hex_multi_if.sv
// Bus between board logic and the hex_multi display driver.
interface hex_multi_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  we;
    logic [AW-1:0]         wdig;
    logic [3:0]            wval;
    logic                  inc;
    logic                  bcd;
    logic                  lz_en;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     blink_en;
    logic [4*DIGITS-1:0]   value;
    logic                  ovf;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output we, wdig, wval, inc, bcd, lz_en, blank, blink_en,
        input  value, ovf, seg
    );

    modport slave (
        input  we, wdig, wval, inc, bcd, lz_en, blank, blink_en,
        output value, ovf, seg
    );
endinterface

// File: rtl/hex_multi.sv
// N-digit hex/BCD 7-segment driver with write port, ripple up-counter,
// per-digit blanking/blinking and leading-zero suppression.
module hex_multi #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned BLINK_DIV  = 26,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst,
    hex_multi_if.slave     bus
);
    localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SW = 7 * DIGITS;
    localparam logic [SW-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {SW{1'b1}} : {SW{1'b0}};

    logic [DIGITS-1:0][3:0] r_dig;
    logic [DIGITS-1:0][3:0] w_dig_inc;
    logic                   w_top_carry;
    logic                   r_ovf;
    logic [BLINK_DIV-1:0]   r_blink;
    logic                   w_phase;
    logic [DIGITS-1:0]      w_lz_off;
    logic [SW-1:0]          w_seg_next;
    logic [SW-1:0]          r_seg;
    logic [AW-1:0]          w_wdig;
    logic                   w_wr_ok;

    // Active-high gfedcba pattern for one nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    assign w_wdig    = bus.wdig;
    assign w_wr_ok   = bus.we && (32'(w_wdig) < DIGITS);
    assign w_phase   = r_blink[BLINK_DIV-1];
    assign bus.value = r_dig;
    assign bus.ovf   = r_ovf;
    assign bus.seg   = r_seg;

    // Ripple-carry increment of the whole value; saturating digits wrap to 0.
    always_comb begin
        logic v_carry;
        w_dig_inc = r_dig;
        v_carry   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v_carry) begin
                if ((bus.bcd && r_dig[i] >= 4'd9) || r_dig[i] == 4'hF) begin
                    w_dig_inc[i] = 4'd0;
                end else begin
                    w_dig_inc[i] = r_dig[i] + 4'd1;
                    v_carry      = 1'b0;
                end
            end
        end
        w_top_carry = v_carry;
    end

    // Leading-zero mask: a digit is off if it and everything above it is zero.
    always_comb begin
        logic v_zero_run;
        w_lz_off   = '0;
        v_zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            v_zero_run  = v_zero_run && (r_dig[i] == 4'd0);
            w_lz_off[i] = bus.lz_en && v_zero_run && (i != 0);
        end
    end

    // Next segment image from digit registers and display controls.
    always_comb begin
        logic [6:0] v_pat;
        logic       v_off;
        w_seg_next = SEG_OFF;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v_off = bus.blank[i] || (bus.blink_en[i] && w_phase) || w_lz_off[i];
            v_pat = v_off ? 7'h00 : f_decode(r_dig[i]);
            w_seg_next[7*i +: 7] = (ACTIVE_LOW != 0) ? ~v_pat : v_pat;
        end
    end

    // Digit registers and overflow pulse; a write takes priority over inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (bus.we) begin
                if (w_wr_ok) begin
                    r_dig[w_wdig] <= bus.wval;
                end
            end else if (bus.inc) begin
                r_dig <= w_dig_inc;
                r_ovf <= w_top_carry;
            end
        end
    end

    // Free-running blink counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BLINK_DIV'(1);
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_OFF;
        end else begin
            r_seg <= w_seg_next;
        end
    end
endmodule

// File: tb/tb_hex_multi.sv
// Randomised + directed bench for hex_multi against an arithmetic reference model.
module tb_hex_multi;
    localparam int unsigned DIGITS = 4;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    hex_multi_if #(.DIGITS(DIGITS)) bus ();

    hex_multi #(
        .DIGITS     (DIGITS),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: whole value as an integer, blink count, outputs.
    int          m_val;
    int          m_cnt;
    logic        m_ovf;
    logic [27:0] m_seg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] model_seg();
        logic [27:0] s;
        logic [6:0]  p;
        bit          off;
        int          nib;
        s = '1;
        for (int i = 0; i < 4; i++) begin
            nib = (m_val >> (4 * i)) & 15;
            off = bus.blank[i] || (bus.blink_en[i] && m_cnt >= 8) ||
                  (bus.lz_en && i > 0 && (m_val >> (4 * i)) == 0);
            p = off ? 7'h00 : DEC[nib];
            s[7*i +: 7] = ~p;
        end
        return s;
    endfunction

    task automatic model_inc();
        int k;
        int d;
        if (!bus.bcd) begin
            m_ovf = (m_val == 16'hFFFF);
            m_val = (m_val + 1) & 16'hFFFF;
        end else begin
            k = -1;
            for (int i = 3; i >= 0; i--) begin
                d = (m_val >> (4 * i)) & 15;
                if (d < 9) k = i;
            end
            if (k < 0) begin
                m_val = 0;
                m_ovf = 1'b1;
            end else begin
                d = (m_val >> (4 * k)) & 15;
                m_val = (m_val & ~((1 << (4 * (k + 1))) - 1)) | ((d + 1) << (4 * k));
            end
        end
    endtask

    // Advance model over one edge using the inputs now driven, then check.
    task automatic step();
        if (rst) begin
            m_val = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_seg = '1;
        end else begin
            m_seg = model_seg();
            m_cnt = (m_cnt + 1) % 16;
            m_ovf = 1'b0;
            if (bus.we) begin
                if (int'(bus.wdig) < 4)
                    m_val = (m_val & ~(15 << (4 * bus.wdig))) | (int'(bus.wval) << (4 * bus.wdig));
            end else if (bus.inc) begin
                model_inc();
            end
        end
        @(negedge clk);
        chk("value", 32'(bus.value), 32'(m_val));
        chk("ovf",   32'(bus.ovf),   32'(m_ovf));
        chk("seg",   32'(bus.seg),   32'(m_seg));
    endtask

    task automatic set_val(input logic [15:0] v);
        bus.inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.we   = 1'b1;
            bus.wdig = 2'(i);
            bus.wval = v[4*i +: 4];
            step();
        end
        bus.we = 1'b0;
    endtask

    initial begin
        logic [27:0] s;
        n_total = 0;
        n_bad   = 0;
        m_val   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_seg   = '1;
        rst          = 1'b1;
        bus.we       = 1'b0;
        bus.wdig     = '0;
        bus.wval     = '0;
        bus.inc      = 1'b0;
        bus.bcd      = 1'b0;
        bus.lz_en    = 1'b0;
        bus.blank    = '0;
        bus.blink_en = '0;

        // Reset and release.
        step();
        step();
        chk("rst_seg", 32'(bus.seg), 32'(28'hFFF_FFFF));
        rst = 1'b0;
        step();
        chk("rel_seg", 32'(bus.seg), 32'({4{7'h40}}));

        // Single digit write, seg follows two edges later.
        bus.we = 1'b1; bus.wdig = 2'd2; bus.wval = 4'hA;
        step();
        chk("wr_value", 32'(bus.value), 32'h0A00);
        bus.we = 1'b0;
        step();
        s = bus.seg;
        chk("wr_seg2", 32'(s[20:14]), 32'h08);

        // Hex wrap with overflow pulse.
        set_val(16'hFFFF);
        bus.inc = 1'b1;
        step();
        chk("hex_wrap", 32'(bus.value), 32'h0000);
        chk("hex_ovf", 32'(bus.ovf), 32'h1);
        bus.inc = 1'b0;
        step();
        chk("hex_ovf_end", 32'(bus.ovf), 32'h0);

        // BCD ripple.
        bus.bcd = 1'b1;
        set_val(16'h0999);
        bus.inc = 1'b1;
        step();
        chk("bcd_ripple", 32'(bus.value), 32'h1000);
        chk("bcd_ovf", 32'(bus.ovf), 32'h0);
        bus.inc = 1'b0;
        bus.bcd = 1'b0;

        // Write beats increment.
        set_val(16'h0009);
        bus.we = 1'b1; bus.wdig = 2'd0; bus.wval = 4'h5; bus.inc = 1'b1;
        step();
        chk("we_inc", 32'(bus.value), 32'h0005);
        bus.we = 1'b0; bus.inc = 1'b0;

        // Leading-zero suppression.
        bus.lz_en = 1'b1;
        set_val(16'h0050);
        step();
        chk("lz_0050", 32'(bus.seg), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
        set_val(16'h0000);
        step();
        chk("lz_0000", 32'(bus.seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        bus.lz_en = 1'b0;

        // Blink on digit 0, then reset mid-period.
        bus.blink_en = 4'b0001;
        for (int i = 0; i < 21; i++) step();
        rst = 1'b1;
        step();
        chk("blink_rst", 32'(bus.seg), 32'(28'hFFF_FFFF));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        bus.blink_en = '0;

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(63) == 0);
            bus.we   = ($urandom_range(2) == 0);
            bus.wdig = 2'($urandom_range(3));
            bus.wval = 4'($urandom);
            bus.inc  = ($urandom_range(1) == 0);
            if ($urandom_range(15) == 0) bus.bcd = ~bus.bcd;
            if ($urandom_range(7) == 0)  bus.lz_en = 1'($urandom);
            bus.blank    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(15) == 0) bus.blink_en = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
